// File: rtl/axi_bridge_ip_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bridge_ip_tx_pkg
//  Description : Shared constants, beat entry type and tkeep helpers for the
//                AXI bridge TX ingress path.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_bridge_ip_tx_pkg;

    // Beat geometry. Top-level parameters default to these values and must
    // match them, because the entry type is built from them.
    localparam int TX_DATA_W         = 256;
    localparam int TX_IF_W           = 64;
    localparam int TX_TUSER_W        = 16;

    localparam int BYTES_PER_SEG     = TX_IF_W / 8;
    localparam int BYTES_PER_BEAT    = TX_DATA_W / 8;
    localparam int MAX_SEGS_PER_BEAT = (TX_DATA_W + TX_IF_W - 1) / TX_IF_W;
    localparam int SEG_CNT_W         = $clog2(MAX_SEGS_PER_BEAT + 1);
    localparam int LAST_BYTES_W      = $clog2(BYTES_PER_BEAT + 1);

    // One buffered beat with its segment bookkeeping precomputed.
    typedef struct packed {
        logic [TX_DATA_W-1:0]      data;
        logic [BYTES_PER_BEAT-1:0] keep;
        logic [TX_TUSER_W-1:0]     user;
        logic                      last;
        logic [SEG_CNT_W-1:0]      num_segs;
        logic [LAST_BYTES_W-1:0]   last_seg_bytes;
    } beat_entry_t;

    // Number of set bits in a tkeep vector.
    function automatic logic [LAST_BYTES_W-1:0] popcount_keep(
        input logic [BYTES_PER_BEAT-1:0] keep
    );
        logic [LAST_BYTES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            cnt = cnt + LAST_BYTES_W'(keep[i]);
        end
        return cnt;
    endfunction

    // True when the set bits form a run starting at bit 0 (all-zero included).
    function automatic logic keep_is_contiguous(
        input logic [BYTES_PER_BEAT-1:0] keep
    );
        for (int i = 1; i < BYTES_PER_BEAT; i++) begin
            if (keep[i] && !keep[i-1]) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_bridge_ip_tx_beat_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bridge_ip_tx_beat_fifo
//  Description : Synchronous FIFO of beat entries. Head is read from
//                registered storage, so a write is visible one cycle later.
//                Supports flush and setting the last bit of the newest entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_bridge_ip_tx_beat_fifo
    import axi_bridge_ip_tx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  beat_entry_t push_entry_i,
    input  logic        pop_i,
    input  logic        set_last_i,
    output beat_entry_t head_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int ADDR_W = PTR_W - 1;

    beat_entry_t        mem_q [DEPTH];
    beat_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0]  w_tail_addr;

    assign w_wr_addr   = wr_ptr_q[ADDR_W-1:0];
    assign w_tail_addr = w_wr_addr - ADDR_W'(1);

    // Wrap bit distinguishes full from empty when the address bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next pointers and storage: flush wins over push/pop/set-last.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[w_wr_addr] = push_entry_i;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (set_last_i && !empty_o) begin
                mem_d[w_tail_addr].last = 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful while occupied.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/axi_bridge_ip_tx_beat_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bridge_ip_tx_beat_fetch
//  Description : TX ingress stage. Buffers AXI-Stream beats, precomputes the
//                segment count and last-segment byte count, and holds the
//                head beat for the segment generator until beat-done.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_bridge_ip_tx_beat_fetch
    import axi_bridge_ip_tx_pkg::*;
#(
    parameter  int DATA_W     = TX_DATA_W,
    parameter  int IF_W       = TX_IF_W,
    parameter  int TUSER_W    = TX_TUSER_W,
    parameter  int FIFO_DEPTH = 2,
    localparam int NSEG_W     = $clog2(((DATA_W + IF_W - 1) / IF_W) + 1),
    localparam int LBYTES_W   = $clog2(DATA_W / 8 + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_W-1:0]     s_axis_tdata_i,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep_i,
    input  logic [TUSER_W-1:0]    s_axis_tuser_i,
    input  logic                  s_axis_tlast_i,
    output logic                  beat_valid_o,
    output logic [DATA_W-1:0]     beat_data_o,
    output logic [DATA_W/8-1:0]   beat_keep_o,
    output logic [TUSER_W-1:0]    beat_user_o,
    output logic                  beat_last_o,
    output logic [NSEG_W-1:0]     beat_num_segs_o,
    output logic [LBYTES_W-1:0]   beat_last_seg_bytes_o,
    input  logic                  beat_done_pulse_i,
    input  logic                  frame_done_pulse_i,
    output logic                  keep_err_o,
    output logic [31:0]           frame_cnt_o
);

    logic                    w_empty;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_null;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_set_last;
    logic [LAST_BYTES_W-1:0] w_nbytes;
    logic [SEG_CNT_W-1:0]    w_num_segs;
    logic [LAST_BYTES_W-1:0] w_last_bytes;
    beat_entry_t             w_entry;
    beat_entry_t             w_head;
    beat_entry_t             w_head_vis;
    logic                    keep_err_q, keep_err_d;
    logic [31:0]             frame_cnt_q, frame_cnt_d;

    // Ready depends only on registered occupancy and the control inputs.
    assign s_axis_tready_o = enable_i && !flush_i && !w_full && !rst_i;
    assign w_accept        = s_axis_tvalid_i && s_axis_tready_o;
    assign w_null          = (s_axis_tkeep_i == '0);
    assign w_push          = w_accept && !w_null;
    // A null beat carrying tlast closes the frame on the newest buffered beat.
    assign w_set_last      = w_accept && w_null && s_axis_tlast_i && !w_empty;
    assign w_pop           = beat_done_pulse_i && !w_empty && enable_i && !flush_i;

    // Segment arithmetic on the incoming beat.
    assign w_nbytes     = popcount_keep(s_axis_tkeep_i);
    assign w_num_segs   = SEG_CNT_W'((int'(w_nbytes) + BYTES_PER_SEG - 1) / BYTES_PER_SEG);
    assign w_last_bytes = w_nbytes - LAST_BYTES_W'((int'(w_num_segs) - 1) * BYTES_PER_SEG);

    // Assemble the entry written into the buffer.
    always_comb begin
        w_entry                = '0;
        w_entry.data           = s_axis_tdata_i;
        w_entry.keep           = s_axis_tkeep_i;
        w_entry.user           = s_axis_tuser_i;
        w_entry.last           = s_axis_tlast_i;
        w_entry.num_segs       = w_num_segs;
        w_entry.last_seg_bytes = w_last_bytes;
    end

    axi_bridge_ip_tx_beat_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_i       (w_push),
        .push_entry_i (w_entry),
        .pop_i        (w_pop),
        .set_last_i   (w_set_last),
        .head_o       (w_head),
        .empty_o      (w_empty),
        .full_o       (w_full)
    );

    // Head fields read as zero whenever nothing is buffered.
    assign w_head_vis            = w_empty ? '0 : w_head;
    assign beat_valid_o          = !w_empty && enable_i;
    assign beat_data_o           = w_head_vis.data;
    assign beat_keep_o           = w_head_vis.keep;
    assign beat_user_o           = w_head_vis.user;
    assign beat_last_o           = w_head_vis.last;
    assign beat_num_segs_o       = w_head_vis.num_segs;
    assign beat_last_seg_bytes_o = w_head_vis.last_seg_bytes;

    // Error pulse for accepted null or non-contiguous tkeep; frame counter.
    always_comb begin
        keep_err_d  = w_accept && (w_null || !keep_is_contiguous(s_axis_tkeep_i));
        frame_cnt_d = frame_cnt_q;
        if (frame_done_pulse_i) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    // Status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keep_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            keep_err_q  <= keep_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign keep_err_o  = keep_err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_bridge_ip_tx_beat_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_bridge_ip_tx_beat_fetch
//  Description : Self-checking bench for axi_bridge_ip_tx_beat_fetch using a
//                scoreboard queue of expected head beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_bridge_ip_tx_beat_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         flush;
    logic         tvalid;
    logic         tready;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [15:0]  tuser;
    logic         tlast;
    logic         beat_valid;
    logic [255:0] beat_data;
    logic [31:0]  beat_keep;
    logic [15:0]  beat_user;
    logic         beat_last;
    logic [2:0]   beat_segs;
    logic [5:0]   beat_lbytes;
    logic         beat_done;
    logic         frame_done;
    logic         keep_err;
    logic [31:0]  frame_cnt;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [15:0]  user;
        logic         last;
        int           segs;
        int           lbytes;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    axi_bridge_ip_tx_beat_fetch dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .enable_i              (enable),
        .flush_i               (flush),
        .s_axis_tvalid_i       (tvalid),
        .s_axis_tready_o       (tready),
        .s_axis_tdata_i        (tdata),
        .s_axis_tkeep_i        (tkeep),
        .s_axis_tuser_i        (tuser),
        .s_axis_tlast_i        (tlast),
        .beat_valid_o          (beat_valid),
        .beat_data_o           (beat_data),
        .beat_keep_o           (beat_keep),
        .beat_user_o           (beat_user),
        .beat_last_o           (beat_last),
        .beat_num_segs_o       (beat_segs),
        .beat_last_seg_bytes_o (beat_lbytes),
        .beat_done_pulse_i     (beat_done),
        .frame_done_pulse_i    (frame_done),
        .keep_err_o            (keep_err),
        .frame_cnt_o           (frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Drive one beat until accepted; record the expected head entry.
    task automatic push_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [15:0] u, input logic l);
        int   guard = 0;
        int   nb    = 0;
        logic contig = 1'b1;
        exp_t e;
        tvalid = 1'b1; tdata = d; tkeep = k; tuser = u; tlast = l;
        #1;
        while (!tready && guard < 40) begin
            tick();
            guard++;
        end
        if (!tready) begin
            check_eq("push_timeout", tready, 1);
            tvalid = 1'b0;
            return;
        end
        tick();
        tvalid = 1'b0;
        for (int i = 0; i < 32; i++) if (k[i]) nb++;
        for (int i = 1; i < 32; i++) if (k[i] && !k[i-1]) contig = 1'b0;
        check_eq("keep_err", keep_err, (nb == 0 || !contig));
        if (nb > 0) begin
            e.data = d; e.keep = k; e.user = u; e.last = l;
            e.segs   = nb / 8 + ((nb % 8) != 0 ? 1 : 0);
            e.lbytes = (nb % 8 == 0) ? 8 : nb % 8;
            sb.push_back(e);
            check_eq("valid_latency", beat_valid, 1);
        end else if (l && sb.size() > 0) begin
            sb[sb.size()-1].last = 1'b1;
        end
    endtask

    // Compare the head beat with the scoreboard and pop it.
    task automatic pop_check(input string tag, input bit chk_full);
        int   guard = 0;
        exp_t e;
        while (!beat_valid && guard < 40) begin
            tick();
            guard++;
        end
        check_eq({tag, "_valid"}, beat_valid, 1);
        if (sb.size() == 0) begin
            check_eq({tag, "_unexpected"}, beat_valid, 0);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, "_data"},   beat_data,   e.data);
        check_eq({tag, "_keep"},   beat_keep,   e.keep);
        check_eq({tag, "_user"},   beat_user,   e.user);
        check_eq({tag, "_last"},   beat_last,   e.last);
        check_eq({tag, "_segs"},   beat_segs,   e.segs);
        check_eq({tag, "_lbytes"}, beat_lbytes, e.lbytes);
        beat_done = 1'b1;
        if (chk_full) begin
            #1;
            check_eq({tag, "_full_pop_tready"}, tready, 0);
        end
        tick();
        beat_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] k;
        int          n;
        rst = 1'b1; enable = 1'b1; flush = 1'b0; tvalid = 1'b0;
        tdata = '0; tkeep = '0; tuser = '0; tlast = 1'b0;
        beat_done = 1'b0; frame_done = 1'b0;

        // Reset state
        tick();
        check_eq("rst_tready", tready, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", beat_valid, 0);
        check_eq("rst_data", beat_data, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_keep_err", keep_err, 0);
        check_eq("post_rst_tready", tready, 1);

        // 1: full beat, frame counter
        push_beat(rand_data(), 32'hFFFF_FFFF, 16'h1111, 1'b1);
        pop_check("t1", 1'b0);
        check_eq("t1_empty", beat_valid, 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check_eq("t1_frame_cnt", frame_cnt, 1);

        // 2: partial beats
        push_beat(rand_data(), 32'h000F_FFFF, 16'h2222, 1'b0);
        push_beat(rand_data(), 32'h0000_0001, 16'h2223, 1'b1);
        pop_check("t2a", 1'b0);
        pop_check("t2b", 1'b0);

        // 3: back-to-back, full, tready reopens a cycle after pop
        push_beat(rand_data(), 32'h0000_00FF, 16'h3331, 1'b0);
        push_beat(rand_data(), 32'h0000_FFFF, 16'h3332, 1'b0);
        check_eq("t3_full_tready", tready, 0);
        pop_check("t3a", 1'b1);
        check_eq("t3_reopen", tready, 1);
        push_beat(rand_data(), 32'h00FF_FFFF, 16'h3333, 1'b1);
        pop_check("t3b", 1'b0);
        pop_check("t3c", 1'b0);
        check_eq("t3_empty", beat_valid, 0);

        // 4: non-contiguous keep, null beat carrying tlast
        push_beat(rand_data(), 32'h0000_00F0, 16'h4441, 1'b0);
        tick();
        check_eq("t4_pulse_once", keep_err, 0);
        push_beat(rand_data(), 32'h0000_0000, 16'h4442, 1'b1);
        check_eq("t4_last_merge", beat_last, 1);
        pop_check("t4a", 1'b0);
        push_beat(rand_data(), 32'h0000_0FFF, 16'h4443, 1'b0);
        pop_check("t4b", 1'b0);

        // enable low holds contents and masks valid
        push_beat(rand_data(), 32'h0000_000F, 16'h4444, 1'b0);
        enable = 1'b0;
        #1;
        check_eq("dis_valid", beat_valid, 0);
        check_eq("dis_tready", tready, 0);
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        enable = 1'b1;
        #1;
        pop_check("dis", 1'b0);

        // 5: flush
        push_beat(rand_data(), 32'h0000_FFFF, 16'h5551, 1'b0);
        push_beat(rand_data(), 32'h0000_FFFF, 16'h5552, 1'b0);
        flush = 1'b1; beat_done = 1'b1;
        tick();
        flush = 1'b0; beat_done = 1'b0;
        #1;
        check_eq("t5_flush_valid", beat_valid, 0);
        sb.delete();
        push_beat(rand_data(), 32'h0000_00FF, 16'h5553, 1'b0);
        tvalid = 1'b1; flush = 1'b1;
        #1;
        check_eq("t5_flush_tready", tready, 0);
        tick();
        tvalid = 1'b0; flush = 1'b0;
        #1;
        check_eq("t5_flush_valid2", beat_valid, 0);
        sb.delete();
        push_beat(rand_data(), 32'h0003_FFFF, 16'h5554, 1'b1);
        pop_check("t5", 1'b0);
        check_eq("t5_alone", beat_valid, 0);
        check_eq("t5_frame_cnt", frame_cnt, 1);

        // 6: reset mid-stream with full FIFO and pending pop
        push_beat(rand_data(), 32'hFFFF_FFFF, 16'h6661, 1'b0);
        push_beat(rand_data(), 32'h0000_FFFF, 16'h6662, 1'b0);
        beat_done = 1'b1; rst = 1'b1;
        tick();
        beat_done = 1'b0; rst = 1'b0;
        #1;
        sb.delete();
        check_eq("t6_valid", beat_valid, 0);
        check_eq("t6_data", beat_data, 0);
        check_eq("t6_keep", beat_keep, 0);
        check_eq("t6_last", beat_last, 0);
        check_eq("t6_segs", beat_segs, 0);
        check_eq("t6_lbytes", beat_lbytes, 0);
        check_eq("t6_frame_cnt", frame_cnt, 0);
        push_beat(rand_data(), 32'h0000_07FF, 16'h6663, 1'b1);
        pop_check("t6", 1'b0);

        // Random contiguous beats, alternating single and paired occupancy
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(1, 32);
            k = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
            push_beat(rand_data(), k, 16'($urandom), 1'($urandom));
            if (i % 2 == 1) begin
                pop_check("rnd_a", 1'b0);
                pop_check("rnd_b", 1'b0);
            end
        end
        check_eq("rnd_empty", beat_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
